// File: rtl/wb_trig_ctrl_regs_if.sv
// Wishbone B3 bus bundle between the PCI-side master and the trigger control bank.
interface wb_trig_ctrl_regs_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
    input  dat_o, ack_o, err_o, rty_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
    output dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/wb_trig_ctrl_regs.sv
// Wishbone B3 register bank for the SPI / clock-sync / JTAG mux / trigger control path.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for cyc&stb; the accepting edge commits the access
// S_SINGLE | classic cycle acked this cycle; no new request taken
// S_BURST  | burst in progress; every cycle with stb held is a new beat
// S_ERROR  | err_o is high for the rejected access; nothing committed
module wb_trig_ctrl_regs #(
  parameter int  N_SCRODS       = 12,
  parameter int  N_SPI          = 4,
  parameter int  MIN_SCRODS_RST = 7,
  localparam int SEL_W          = (N_SPI > 1) ? $clog2(N_SPI) : 1,
  localparam int CNT_W          = $clog2(N_SCRODS + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  wb_trig_ctrl_regs_if.slave   wb,
  input  logic [31:0]          SPI_I,
  input  logic                 SPI_DONE_I,
  output logic [31:0]          SPI_O,
  output logic                 SPI_START_O,
  output logic [SEL_W-1:0]     SPI_SEL_O,
  output logic                 SYNC,
  output logic [3:0]           JTAG_MUX_SEL,
  output logic [N_SCRODS-1:0]  TRG_MASK,
  output logic [CNT_W-1:0]     MIN_SCRODS_REQUIRED,
  input  logic [31:0]          TRG_STATISTICS,
  output logic                 TRG_SOFT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SINGLE = 2'd1,
    S_BURST  = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [2:0] W_SPI_TX = 3'd0;
  localparam logic [2:0] W_SPI_RX = 3'd1;
  localparam logic [2:0] W_CTRL   = 3'd2;
  localparam logic [2:0] W_JTAG   = 3'd3;
  localparam logic [2:0] W_MASK   = 3'd4;
  localparam logic [2:0] W_TRGCFG = 3'd5;
  localparam logic [2:0] W_STAT   = 3'd6;
  localparam logic [2:0] W_STICKY = 3'd7;

  localparam logic [CNT_W-1:0] MIN_RST = CNT_W'(MIN_SCRODS_RST);

  state_t               state_q;
  logic [31:0]          spi_tx_q;
  logic                 start_q;
  logic [SEL_W-1:0]     spi_sel_q;
  logic                 sync_q;
  logic [3:0]           jtag_q;
  logic [N_SCRODS-1:0]  mask_q;
  logic [CNT_W-1:0]     min_q;
  logic                 soft_q;
  logic                 done_q;
  logic                 done_rise_q;
  logic                 done_seen_q;
  logic                 err_seen_q;

  logic [9:0]           word_idx;
  logic [2:0]           reg_idx;
  logic                 in_range;
  logic                 take;
  logic                 cti_single;
  logic                 cti_burst;
  logic                 legal;
  logic                 beat_ok;
  logic                 beat_err;
  logic                 wr_ok;
  logic                 rd_ok;
  logic [31:0]          rd_data;
  logic                 unused_adr;

  // Classify the current cycle: is a beat being taken, and is it legal.
  always_comb begin
    word_idx   = wb.adr_i[11:2];
    reg_idx    = word_idx[2:0];
    in_range   = (word_idx[9:3] == 7'd0);
    take       = wb.cyc_i && wb.stb_i && ((state_q == S_IDLE) || (state_q == S_BURST));
    cti_single = (wb.cti_i == CTI_CLASSIC) || (wb.cti_i == CTI_END);
    cti_burst  = (wb.cti_i == CTI_CONST) || (wb.cti_i == CTI_INCR);
    if (state_q == S_IDLE) begin
      legal = in_range && (cti_single || (cti_burst && (wb.bte_i == 2'b00)));
    end else begin
      legal = in_range && (cti_burst || (wb.cti_i == CTI_END));
    end
    beat_ok  = take && legal;
    beat_err = take && !legal;
    wr_ok    = beat_ok && wb.we_i;
    rd_ok    = beat_ok && !wb.we_i;
  end

  // Read mux; unused bits of every register read as zero.
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      W_SPI_TX: rd_data = spi_tx_q;
      W_SPI_RX: rd_data = SPI_I;
      W_CTRL: begin
        rd_data[0]          = start_q;
        rd_data[1]          = SPI_DONE_I;
        rd_data[2 +: SEL_W] = spi_sel_q;
        rd_data[8]          = sync_q;
      end
      W_JTAG:   rd_data[3:0] = jtag_q;
      W_MASK:   rd_data[N_SCRODS-1:0] = mask_q;
      W_TRGCFG: rd_data[CNT_W-1:0] = min_q;
      W_STAT:   rd_data = TRG_STATISTICS;
      W_STICKY: rd_data[1:0] = {err_seen_q, done_seen_q};
      default:  rd_data = '0;
    endcase
  end

  // Bus FSM with registered terminations; a request at edge N is answered in cycle N+1.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      wb.ack_o <= 1'b0;
      wb.err_o <= 1'b0;
    end else begin
      wb.ack_o <= beat_ok;
      wb.err_o <= beat_err;
      case (state_q)
        S_IDLE: begin
          if (beat_err) begin
            state_q <= S_ERROR;
          end else if (beat_ok) begin
            state_q <= cti_single ? S_SINGLE : S_BURST;
          end
        end
        S_BURST: begin
          if (beat_err) begin
            state_q <= S_ERROR;
          end else if (beat_ok && cti_burst) begin
            state_q <= S_BURST;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Registered read data, captured on the accepting edge of a read.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wb.dat_o <= '0;
    end else begin
      wb.dat_o <= rd_ok ? rd_data : 32'd0;
    end
  end

  // Register writes, done-edge handling and sticky status; order gives write/set priority.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      spi_tx_q    <= '0;
      start_q     <= 1'b0;
      spi_sel_q   <= '0;
      sync_q      <= 1'b1;
      jtag_q      <= '0;
      mask_q      <= '1;
      min_q       <= MIN_RST;
      soft_q      <= 1'b0;
      done_q      <= 1'b0;
      done_rise_q <= 1'b0;
      done_seen_q <= 1'b0;
      err_seen_q  <= 1'b0;
    end else begin
      done_q      <= SPI_DONE_I;
      done_rise_q <= SPI_DONE_I && !done_q;
      soft_q      <= 1'b0;
      if (done_rise_q) begin
        start_q <= 1'b0;
      end
      if (wr_ok) begin
        case (reg_idx)
          W_SPI_TX: begin
            for (int b = 0; b < 4; b++) begin
              if (wb.sel_i[b]) begin
                spi_tx_q[8*b +: 8] <= wb.dat_i[8*b +: 8];
              end
            end
          end
          W_CTRL: begin
            if (wb.sel_i[0]) begin
              start_q   <= wb.dat_i[0];
              spi_sel_q <= wb.dat_i[2 +: SEL_W];
            end
            if (wb.sel_i[1]) begin
              sync_q <= wb.dat_i[8];
            end
          end
          W_JTAG: begin
            if (wb.sel_i[0]) begin
              jtag_q <= wb.dat_i[3:0];
            end
          end
          W_MASK: begin
            if (wb.sel_i[0]) begin
              mask_q <= wb.dat_i[N_SCRODS-1:0];
            end
          end
          W_TRGCFG: begin
            if (wb.sel_i[0]) begin
              min_q <= wb.dat_i[CNT_W-1:0];
            end
            if (wb.sel_i[2]) begin
              soft_q <= wb.dat_i[16];
            end
          end
          W_STICKY: begin
            if (wb.sel_i[0]) begin
              if (wb.dat_i[0]) done_seen_q <= 1'b0;
              if (wb.dat_i[1]) err_seen_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      if (done_rise_q) begin
        done_seen_q <= 1'b1;
      end
      if (beat_err) begin
        err_seen_q <= 1'b1;
      end
    end
  end

  assign wb.rty_o            = 1'b0;
  assign SPI_O               = spi_tx_q;
  assign SPI_START_O         = start_q;
  assign SPI_SEL_O           = spi_sel_q;
  assign SYNC                = sync_q;
  assign JTAG_MUX_SEL        = jtag_q;
  assign TRG_MASK            = mask_q;
  assign MIN_SCRODS_REQUIRED = min_q;
  assign TRG_SOFT            = soft_q;

  assign unused_adr = ^{wb.adr_i[31:12], wb.adr_i[1:0]};

endmodule

// File: tb/tb_wb_trig_ctrl_regs.sv
// Directed bench for wb_trig_ctrl_regs with default parameters (12 SCRODs, 4 SPI targets).
module tb_wb_trig_ctrl_regs;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] SPI_I;
  logic        SPI_DONE_I;
  logic [31:0] SPI_O;
  logic        SPI_START_O;
  logic [1:0]  SPI_SEL_O;
  logic        SYNC;
  logic [3:0]  JTAG_MUX_SEL;
  logic [11:0] TRG_MASK;
  logic [3:0]  MIN_SCRODS_REQUIRED;
  logic [31:0] TRG_STATISTICS;
  logic        TRG_SOFT;

  int checks = 0;
  int errors = 0;

  wb_trig_ctrl_regs_if bus ();

  wb_trig_ctrl_regs #(.N_SCRODS(12), .N_SPI(4), .MIN_SCRODS_RST(7)) dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .wb                  (bus),
    .SPI_I               (SPI_I),
    .SPI_DONE_I          (SPI_DONE_I),
    .SPI_O               (SPI_O),
    .SPI_START_O         (SPI_START_O),
    .SPI_SEL_O           (SPI_SEL_O),
    .SYNC                (SYNC),
    .JTAG_MUX_SEL        (JTAG_MUX_SEL),
    .TRG_MASK            (TRG_MASK),
    .MIN_SCRODS_REQUIRED (MIN_SCRODS_REQUIRED),
    .TRG_STATISTICS      (TRG_STATISTICS),
    .TRG_SOFT            (TRG_SOFT)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we; bus.adr_i = adr;
    bus.dat_i = dat; bus.sel_i = sel; bus.cti_i = cti; bus.bte_i = bte;
  endtask

  task automatic release_bus();
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.cti_i = 3'b000; bus.bte_i = 2'b00;
  endtask

  // One bounded transfer; lat stays 0 if no termination arrives within 8 cycles.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte,
                         output logic [31:0] rdat, output logic got_ack, output logic got_err,
                         output int lat, output logic term_after);
    drive(we, adr, dat, sel, cti, bte);
    rdat = '0; got_ack = 1'b0; got_err = 1'b0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk_i); #1;
      if (bus.ack_o || bus.err_o) begin
        got_ack = bus.ack_o; got_err = bus.err_o; rdat = bus.dat_o; lat = i;
        break;
      end
    end
    release_bus();
    @(posedge clk_i); #1;
    term_after = bus.ack_o | bus.err_o;
  endtask

  task automatic wb_write(input int word, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd; logic a, e, t; int l;
    wb_xfer(1'b1, 32'(word * 4), dat, sel, 3'b000, 2'b00, rd, a, e, l, t);
    checks++; if (!(a === 1'b1 && l == 1)) begin errors++; $display("FAIL write_ack word %0d: ack %b lat %0d, want ack 1 lat 1", word, a, l); end
  endtask

  task automatic wb_read(input int word, output logic [31:0] rd);
    logic a, e, t; int l;
    wb_xfer(1'b0, 32'(word * 4), 32'd0, 4'hF, 3'b000, 2'b00, rd, a, e, l, t);
    checks++; if (!(a === 1'b1 && l == 1)) begin errors++; $display("FAIL read_ack word %0d: ack %b lat %0d, want ack 1 lat 1", word, a, l); end
  endtask

  task automatic test_reset();
    logic [31:0] exp_rst [8];
    logic [31:0] rd; logic a, e, t; int l;
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i); #1;
    checks++; if ({bus.ack_o, bus.err_o, bus.rty_o} !== 3'b000) begin errors++; $display("FAIL rst_term: got %b want 000", {bus.ack_o, bus.err_o, bus.rty_o}); end
    checks++; if (bus.dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat_o: got %h want 0", bus.dat_o); end
    checks++; if ({SPI_O, SPI_START_O, SPI_SEL_O, SYNC} !== {32'h0, 1'b0, 2'b00, 1'b1}) begin errors++; $display("FAIL rst_spi: got %h %b %b %b", SPI_O, SPI_START_O, SPI_SEL_O, SYNC); end
    checks++; if ({JTAG_MUX_SEL, TRG_MASK, MIN_SCRODS_REQUIRED, TRG_SOFT} !== {4'h0, 12'hFFF, 4'd7, 1'b0}) begin errors++; $display("FAIL rst_trg: got %h %h %0d %b", JTAG_MUX_SEL, TRG_MASK, MIN_SCRODS_REQUIRED, TRG_SOFT); end
    reset_i = 1'b0;
    exp_rst[0] = 32'h0; exp_rst[1] = 32'h1234_5678; exp_rst[2] = 32'h100; exp_rst[3] = 32'h0;
    exp_rst[4] = 32'hFFF; exp_rst[5] = 32'h7; exp_rst[6] = 32'hCAFE_0001; exp_rst[7] = 32'h0;
    for (int w = 0; w < 8; w++) begin
      wb_xfer(1'b0, 32'(w * 4), 32'd0, 4'hF, 3'b000, 2'b00, rd, a, e, l, t);
      checks++; if (rd !== exp_rst[w]) begin errors++; $display("FAIL rst_read word %0d: got %h want %h", w, rd, exp_rst[w]); end
      checks++; if (!(a === 1'b1 && e === 1'b0 && l == 1)) begin errors++; $display("FAIL rst_read_lat word %0d: ack %b err %b lat %0d, want 1 0 1", w, a, e, l); end
      checks++; if (t !== 1'b0) begin errors++; $display("FAIL rst_read_width word %0d: ack still %b, want 0", w, t); end
    end
  endtask

  task automatic test_spi_tx();
    logic [31:0] rd;
    wb_write(0, 32'hA5A5_A5A5, 4'b0101);
    checks++; if (SPI_O !== 32'h00A5_00A5) begin errors++; $display("FAIL spi_o_lanes: got %h want 00a500a5", SPI_O); end
    wb_read(0, rd);
    checks++; if (rd !== 32'h00A5_00A5) begin errors++; $display("FAIL spi_tx_read: got %h want 00a500a5", rd); end
  endtask

  task automatic test_start_done();
    logic [31:0] rd;
    wb_write(2, 32'h0000_000D, 4'hF);
    checks++; if ({SPI_START_O, SPI_SEL_O, SYNC} !== 4'b1110) begin errors++; $display("FAIL ctrl_outs: got %b want 1110", {SPI_START_O, SPI_SEL_O, SYNC}); end
    SPI_DONE_I = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (SPI_START_O !== 1'b1) begin errors++; $display("FAIL start_early: got %b want 1 one edge after done", SPI_START_O); end
    @(posedge clk_i); #1;
    checks++; if (SPI_START_O !== 1'b0) begin errors++; $display("FAIL start_clear: got %b want 0 two edges after done", SPI_START_O); end
    wb_read(7, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL done_seen: got %h want 1", rd); end
    wb_read(2, rd);
    checks++; if (rd !== 32'h0000_000E) begin errors++; $display("FAIL ctrl_read: got %h want 0000000e", rd); end
    wb_write(7, 32'h1, 4'h1);
    wb_read(7, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL done_w1c: got %h want 0", rd); end
    SPI_DONE_I = 1'b0;
  endtask

  task automatic test_collisions();
    logic [31:0] rd;
    repeat (2) @(posedge clk_i); #1;
    SPI_DONE_I = 1'b1;
    @(posedge clk_i); #1;
    drive(1'b1, 32'h8, 32'h0000_000D, 4'hF, 3'b000, 2'b00);
    @(posedge clk_i); #1;
    checks++; if ({bus.ack_o, SPI_START_O} !== 2'b11) begin errors++; $display("FAIL start_write_wins: ack,start %b want 11", {bus.ack_o, SPI_START_O}); end
    release_bus();
    @(posedge clk_i); #1;
    checks++; if (SPI_START_O !== 1'b1) begin errors++; $display("FAIL start_hold: got %b want 1", SPI_START_O); end
    SPI_DONE_I = 1'b0;
    repeat (2) @(posedge clk_i); #1;
    SPI_DONE_I = 1'b1;
    @(posedge clk_i); #1;
    drive(1'b1, 32'h1C, 32'h1, 4'h1, 3'b000, 2'b00);
    @(posedge clk_i); #1;
    checks++; if ({bus.ack_o, SPI_START_O} !== 2'b10) begin errors++; $display("FAIL done_clears_start: ack,start %b want 10", {bus.ack_o, SPI_START_O}); end
    release_bus();
    @(posedge clk_i); #1;
    wb_read(7, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL sticky_set_wins: got %h want 1", rd); end
    SPI_DONE_I = 1'b0;
    wb_write(7, 32'h1, 4'h1);
  endtask

  task automatic test_soft();
    logic [31:0] dat_v [2];
    logic [3:0]  sel_v [2];
    logic        soft_v [2];
    logic [3:0]  min_v [2];
    logic [31:0] rd;
    dat_v[0] = 32'h0001_0009; sel_v[0] = 4'hF; soft_v[0] = 1'b1; min_v[0] = 4'd9;
    dat_v[1] = 32'h0001_0005; sel_v[1] = 4'h1; soft_v[1] = 1'b0; min_v[1] = 4'd5;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h14, dat_v[k], sel_v[k], 3'b000, 2'b00);
      @(posedge clk_i); #1;
      checks++; if ({bus.ack_o, TRG_SOFT} !== {1'b1, soft_v[k]}) begin errors++; $display("FAIL soft_pulse %0d: ack,soft %b want 1%b", k, {bus.ack_o, TRG_SOFT}, soft_v[k]); end
      checks++; if (MIN_SCRODS_REQUIRED !== min_v[k]) begin errors++; $display("FAIL min_out %0d: got %0d want %0d", k, MIN_SCRODS_REQUIRED, min_v[k]); end
      release_bus();
      @(posedge clk_i); #1;
      checks++; if (TRG_SOFT !== 1'b0) begin errors++; $display("FAIL soft_width %0d: got %b want 0", k, TRG_SOFT); end
      wb_read(5, rd);
      checks++; if (rd !== 32'(min_v[k])) begin errors++; $display("FAIL trgcfg_read %0d: got %h want %h", k, rd, 32'(min_v[k])); end
    end
  endtask

  task automatic test_burst_read();
    logic [31:0] exp_b [4];
    logic [31:0] rd;
    wb_write(3, 32'h0000_000A, 4'h1);
    wb_write(4, 32'hFFFF_F5A5, 4'h1);
    checks++; if ({JTAG_MUX_SEL, TRG_MASK} !== {4'hA, 12'h5A5}) begin errors++; $display("FAIL jtag_mask: got %h %h want a 5a5", JTAG_MUX_SEL, TRG_MASK); end
    exp_b[0] = 32'hA; exp_b[1] = 32'h5A5; exp_b[2] = 32'h5; exp_b[3] = 32'hCAFE_0001;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'((3 + i) * 4), 32'd0, 4'hF, (i == 3) ? 3'b111 : 3'b010, 2'b00);
      @(posedge clk_i); #1;
      checks++; if ({bus.ack_o, bus.err_o} !== 2'b10 || bus.dat_o !== exp_b[i]) begin errors++; $display("FAIL burst_beat %0d: ack %b err %b dat %h want 1 0 %h", i, bus.ack_o, bus.err_o, bus.dat_o, exp_b[i]); end
    end
    release_bus();
    @(posedge clk_i); #1;
    checks++; if (bus.ack_o !== 1'b0) begin errors++; $display("FAIL burst_end: ack %b want 0", bus.ack_o); end
    wb_read(4, rd);
    checks++; if (rd !== 32'h5A5) begin errors++; $display("FAIL after_burst: got %h want 5a5", rd); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h14, 32'h0001_0003 + 32'(i), 4'hF, (i == 1) ? 3'b111 : 3'b001, 2'b00);
      @(posedge clk_i); #1;
      checks++; if ({bus.ack_o, TRG_SOFT} !== 2'b11 || MIN_SCRODS_REQUIRED !== 4'(3 + i)) begin errors++; $display("FAIL b2b_beat %0d: ack %b soft %b min %0d want 1 1 %0d", i, bus.ack_o, TRG_SOFT, MIN_SCRODS_REQUIRED, 3 + i); end
    end
    release_bus();
    @(posedge clk_i); #1;
    checks++; if ({bus.ack_o, TRG_SOFT} !== 2'b00) begin errors++; $display("FAIL b2b_end: ack,soft %b want 00", {bus.ack_o, TRG_SOFT}); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic a, e, t; int l;
    wb_xfer(1'b0, 32'h24, 32'd0, 4'hF, 3'b000, 2'b00, rd, a, e, l, t);
    checks++; if (!(a === 1'b0 && e === 1'b1 && l == 1 && t === 1'b0)) begin errors++; $display("FAIL err_range: ack %b err %b lat %0d after %b want 0 1 1 0", a, e, l, t); end
    wb_xfer(1'b1, 32'h8, 32'h1, 4'hF, 3'b011, 2'b00, rd, a, e, l, t);
    checks++; if (!(a === 1'b0 && e === 1'b1 && l == 1)) begin errors++; $display("FAIL err_cti: ack %b err %b lat %0d want 0 1 1", a, e, l); end
    checks++; if ({SPI_START_O, SPI_SEL_O, SYNC} !== 4'b0110) begin errors++; $display("FAIL err_no_commit_ctrl: got %b want 0110", {SPI_START_O, SPI_SEL_O, SYNC}); end
    wb_xfer(1'b1, 32'h10, 32'h0, 4'h1, 3'b010, 2'b01, rd, a, e, l, t);
    checks++; if (!(a === 1'b0 && e === 1'b1) || TRG_MASK !== 12'h5A5) begin errors++; $display("FAIL err_bte: ack %b err %b mask %h want 0 1 5a5", a, e, TRG_MASK); end
    drive(1'b0, 32'h0, 32'd0, 4'hF, 3'b010, 2'b00);
    @(posedge clk_i); #1;
    checks++; if ({bus.ack_o, bus.err_o} !== 2'b10) begin errors++; $display("FAIL err_midburst_ok: ack,err %b want 10", {bus.ack_o, bus.err_o}); end
    drive(1'b0, 32'h20, 32'd0, 4'hF, 3'b010, 2'b00);
    @(posedge clk_i); #1;
    checks++; if ({bus.ack_o, bus.err_o} !== 2'b01) begin errors++; $display("FAIL err_midburst_range: ack,err %b want 01", {bus.ack_o, bus.err_o}); end
    release_bus();
    @(posedge clk_i); #1;
    checks++; if ({bus.ack_o, bus.err_o} !== 2'b00) begin errors++; $display("FAIL err_width: ack,err %b want 00", {bus.ack_o, bus.err_o}); end
    wb_read(7, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL err_seen: got %h want 2", rd); end
    wb_write(7, 32'h2, 4'h1);
    wb_read(7, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_w1c: got %h want 0", rd); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] rd; logic a, e, t; int l;
    wb_xfer(1'b0, 32'h24, 32'd0, 4'hF, 3'b000, 2'b00, rd, a, e, l, t);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'(i * 4), 32'd0, 4'hF, 3'b010, 2'b00);
      @(posedge clk_i); #1;
      checks++; if (bus.ack_o !== 1'b1) begin errors++; $display("FAIL rmb_beat %0d: ack %b want 1", i, bus.ack_o); end
    end
    drive(1'b0, 32'h8, 32'd0, 4'hF, 3'b010, 2'b00);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    checks++; if ({bus.ack_o, bus.err_o} !== 2'b00 || bus.dat_o !== 32'h0) begin errors++; $display("FAIL rmb_term: ack %b err %b dat %h want 0 0 0", bus.ack_o, bus.err_o, bus.dat_o); end
    checks++; if ({SPI_O, SPI_START_O, SPI_SEL_O, SYNC} !== {32'h0, 1'b0, 2'b00, 1'b1}) begin errors++; $display("FAIL rmb_spi: got %h %b %b %b", SPI_O, SPI_START_O, SPI_SEL_O, SYNC); end
    checks++; if ({JTAG_MUX_SEL, TRG_MASK, MIN_SCRODS_REQUIRED, TRG_SOFT} !== {4'h0, 12'hFFF, 4'd7, 1'b0}) begin errors++; $display("FAIL rmb_trg: got %h %h %0d %b", JTAG_MUX_SEL, TRG_MASK, MIN_SCRODS_REQUIRED, TRG_SOFT); end
    release_bus();
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    checks++; if (bus.ack_o !== 1'b0) begin errors++; $display("FAIL rmb_no_ack: ack %b want 0", bus.ack_o); end
    wb_read(7, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rmb_sticky: got %h want 0", rd); end
  endtask

  initial begin
    release_bus();
    bus.adr_i = '0; bus.dat_i = '0; bus.sel_i = '0;
    SPI_I = 32'h1234_5678; SPI_DONE_I = 1'b0; TRG_STATISTICS = 32'hCAFE_0001;
    reset_i = 1'b1;
    test_reset();
    test_spi_tx();
    test_start_done();
    test_collisions();
    test_soft();
    test_burst_read();
    test_back_to_back();
    test_errors();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_trig_ctrl_regs.md
# wb_trig_ctrl_regs

Parametrised Wishbone B3 slave register bank for the trigger/SPI/JTAG control path of the PCI bridge firmware. It sits between the PCI-side Wishbone master and the SPI controller, clock-sync line, JTAG mux and trigger logic. It generalises the control bank to N SCRODs and N SPI targets. It adds registered read data, address-range errors, self-clearing command bits and write-1-to-clear sticky status.

## Interface
- N_SCRODS, 12, trigger-mask width (1..16)
- N_SPI, 4, SPI target count; SEL_W = max(1, clog2(N_SPI))
- MIN_SCRODS_RST, 7, reset value of MIN_SCRODS_REQUIRED; CNT_W = clog2(N_SCRODS+1)
- clk_i  in  1  sole clock, all logic rising-edge
- reset_i  in  1  synchronous, active-high reset
- cyc_i, stb_i, we_i  in  1  Wishbone cycle, strobe, write enable
- adr_i  in  32  byte address; word index = adr_i[11:2]
- dat_i  in  32  write data
- sel_i  in  4  byte lanes
- cti_i  in  3  cycle type
- bte_i  in  2  burst type
- dat_o  out  32  registered read data
- ack_o, err_o  out  1  terminations, mutually exclusive
- rty_o  out  1  tied 0
- SPI_I  in  32  SPI receive word
- SPI_DONE_I  in  1  SPI transfer complete (level)
- SPI_O  out  32  SPI transmit word
- SPI_START_O  out  1  SPI start request
- SPI_SEL_O  out  SEL_W  SPI target select
- SYNC  out  1  clock-sync line
- JTAG_MUX_SEL  out  4  JTAG chain select
- TRG_MASK  out  N_SCRODS  SCROD enable mask
- MIN_SCRODS_REQUIRED  out  CNT_W  coincidence threshold
- TRG_STATISTICS  in  32  trigger count
- TRG_SOFT  out  1  one-cycle soft-trigger pulse

## Operation
- Register map, word index:
  - 0 SPI_TX: rw, byte-lane writes to SPI_O.
  - 1 SPI_RX: ro, SPI_I.
  - 2 CTRL: bit0 START, bit1 DONE (ro), bits[2+:SEL_W] SEL, bit8 SYNC.
  - 3 JTAG: [3:0].
  - 4 MASK: [N_SCRODS-1:0].
  - 5 TRGCFG: [CNT_W-1:0] min SCRODs; bit16 SOFT, write-1 pulse, reads 0.
  - 6 STAT: ro, TRG_STATISTICS.
  - 7 STICKY: bit0 DONE_SEEN, bit1 ERR_SEEN; write 1 clears.
- Byte lanes: a field updates only if the sel_i lane holding its bit 0 is set. Unused bits read 0. Writes to ro registers are acked and ignored.
- FSM states:
  - IDLE: on cyc_i&stb_i, go to SINGLE if cti 000/111, BURST if cti 001/010 with bte 00, else ERROR.
  - SINGLE: returns to IDLE.
  - BURST: each beat held; stays in BURST on cti 001/010; returns to IDLE on cti 111; goes to ERROR on any other cti.
  - ERROR: returns to IDLE.
  - A word index >= 8 also forces ERROR.
- Classic single: one ack per stb. No new request is accepted in the cycle ack_o is high.
- Burst: one ack per cycle while stb_i is held. Each beat is decoded from that cycle's adr_i. No internal address increment.
- Commit: write effects and the read mux capture happen on the accepting edge. ERROR commits nothing and sets ERR_SEEN.
- START: set by writing CTRL bit0=1; cleared by writing 0 or by a SPI_DONE_I rising edge (1-cycle registered edge detect). If a write and a done edge land on the same edge, the write wins.
- DONE_SEEN: set on the SPI_DONE_I rising edge. If set and a W1C land on the same edge, set wins.
- SOFT: TRG_SOFT is high exactly one cycle after the commit edge. Back-to-back writes give back-to-back pulses.
- Reset values:
  - ack_o 0, err_o 0, dat_o 0
  - SPI_O 0, SPI_START_O 0, SPI_SEL_O 0, SYNC 1
  - JTAG_MUX_SEL 0, TRG_MASK all ones, MIN_SCRODS_REQUIRED MIN_SCRODS_RST, TRG_SOFT 0
  - sticky bits 0, FSM IDLE
- Reset mid-burst: all of the above take effect on the next edge; the burst is abandoned with no ack.

## Timing
- Request at edge N produces ack_o/err_o and dat_o valid during cycle N+1 (latency 1).
- Write effects are visible on outputs in cycle N+1. A read-back in the next transfer returns the new value.
- Classic single: ack pulse is 1 cycle wide; maximum rate is one transfer per 2 cycles.
- Burst: ack is continuous, 1 beat per cycle; ack deasserts the cycle after stb_i falls.
- TRG_SOFT and START clear are 1-cycle events. No combinational path from any input to any output.

## Test plan
- Reset, then read words 0..7 -> SPI_TX 0, CTRL 0x100, JTAG 0, MASK 0xFFF, TRGCFG 7, STICKY 0; each ack exactly one cycle after stb.
- Write 0xA5A5A5A5 to word 0 with sel 0101, then read -> 0x00A500A5; SPI_O matches.
- Write CTRL 0x00D (START=1, SEL=3), pulse SPI_DONE_I 0->1 -> SPI_START_O drops two edges after the rise; DONE_SEEN=1; writing STICKY 0x1 clears it.
- Write TRGCFG 0x10009 -> TRG_SOFT high exactly 1 cycle; MIN_SCRODS_REQUIRED=9; read TRGCFG -> 0x9.
- 4-beat incrementing burst read at words 3..6 with cti 010,010,010,111 -> 4 consecutive acks, correct data, FSM back in IDLE.
- Access word 9; cti 011; burst with bte 01 -> err_o one cycle, no ack, no register change, ERR_SEEN=1; reset asserted mid-burst -> no further ack, all outputs at reset values.
